orbus_read_ctl: RTL and testbench
=================================

# orbus_read_ctl

Read-cycle controller for the emulator OR-bus read-data path. Two requesters, the CPU read port and the host debug port, share the bus through a round-robin arbiter. The controller decodes the address into a one-hot source select and drives the DataFlash mask (`SLDFLASH`). It waits for the selected source to signal ready, then captures the 16-bit OR-bus result (`MDR_RAM`) into the winning requester's data register.

## Interface

Parameters:
- `ADR_W`, default 20: request address width; minimum 18.
- `TMO_W`, default 8: timeout counter width. Used only with `ORBUS_TMO_EN`.

Ports (name, direction, width, meaning):
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RESB` in 1: reset, asynchronous, active-low.
- `CPUREQ` in 1: CPU read request (level).
- `CPUADR` in `ADR_W`: CPU read address.
- `CPUACK` out 1: one-cycle pulse; `CPURDATA` is valid.
- `CPURDATA` out 16: CPU read data, held until the next CPU capture.
- `HSTREQ` in 1: host read request (level).
- `HSTADR` in `ADR_W`: host read address.
- `HSTACK` out 1: one-cycle pulse; `HSTRDATA` is valid.
- `HSTRDATA` out 16: host read data, held until the next host capture.
- `RDERR` out 1: timeout flag; valid with the ACK pulse.
- `SELMEM` out 1: memory source select.
- `SELTRACE` out 1: trace source select.
- `SELSTATE` out 1: status source select.
- `SELBRK` out 1: break source select.
- `SELHOSTIF` out 1: host-IF source select.
- `SELDF` out 1: DataFlash-emulator source select.
- `SLDFLASH` out 1: DataFlash read in progress; masks IRAM data on the OR-bus.
- `SRCRDY` in 1: selected source has valid data on the OR-bus this cycle.
- `MDR_RAM` in 16: OR-bus result.
- `BUSY` out 1: a read cycle is in progress (state ≠ IDLE).

## Operation

Address decode, on `ADR[ADR_W-1 : ADR_W-3]` of the granted address:
- `0xx` → MEM
- `100` → TRACE
- `101` → STATE
- `110` → BRK
- `111` with `ADR[ADR_W-4]=0` → HOSTIF
- `111` with `ADR[ADR_W-4]=1` → DF; also asserts `SLDFLASH`.

Exactly one `SEL*` is high in the SEL state. All `SEL*` and `SLDFLASH` are low in every other state. `SLDFLASH` is never high together with `SELMEM`.

State machine (registered; IDLE is the reset state):
- IDLE: if any request is pending, grant one, latch its address and owner, go to SEL.
- SEL: drive the decoded select.
  - If `SRCRDY=1`, capture `MDR_RAM` into the owner's RDATA and go to DONE.
  - With `ORBUS_TMO_EN`, see Configuration for timeout.
- DONE: pulse the owner's ACK for one cycle, go to IDLE.

Arbitration:
- Round-robin pointer `last` records the last served requester.
- If both request in IDLE, the requester not equal to `last` wins.
- If only one requests, it wins regardless of `last`.
- `last` updates on grant. Reset value is host, so the CPU wins the first tie.

Requester rules:
- A requester holds REQ and ADR stable until its ACK.
- A requester deasserts REQ in the cycle after ACK. REQ still high in the IDLE cycle after DONE is taken as a new request.
- Address changes after grant are ignored; the address is latched.

Data rules:
- RDATA of the non-owner is unchanged.
- `RDERR` is 0 on every successful capture.

## Timing

Reset values (asynchronously on `RESB=0`): every output 0, `CPURDATA`/`HSTRDATA` = 16'h0000, state IDLE, `last` = host. Reset mid-cycle aborts the read with no ACK.

Latency:
- REQ high at cycle 0 (IDLE) → `SEL*` high in cycle 1.
- With `SRCRDY=1` in cycle 1: capture at the end of cycle 1, ACK high in cycle 2.
- Minimum REQ-to-ACK is 2 cycles. Each extra cycle with `SRCRDY=0` adds one cycle.

Throughput: back-to-back reads take 3 cycles each (IDLE, SEL, DONE).

Boundaries:
- A request arriving during SEL/DONE waits; it is arbitrated in the next IDLE.
- `SRCRDY` is ignored outside SEL.

## Configuration

`ORBUS_TMO_EN`:
- Defined:
  - A `TMO_W`-bit counter clears on entering SEL and increments each SEL cycle.
  - If `SRCRDY=0` when the count equals all-ones (2^`TMO_W`-1 SEL cycles elapsed), the owner's RDATA is loaded with 16'hFFFF. The FSM goes to DONE, and `RDERR=1` during the ACK cycle.
  - If `SRCRDY=1` in that same cycle, the capture wins and `RDERR=0`.
- Undefined: no counter is built. SEL waits indefinitely and `RDERR` is tied to 0.

## Test plan

- Reset → all outputs 0 and `BUSY=0`. Then CPU reads `CPUADR=20'h00100` with `SRCRDY=1` immediately and `MDR_RAM=16'h1234` → `SELMEM` in cycle 1, `CPUACK` in cycle 2, `CPURDATA=16'h1234`.
- Host reads `HSTADR=20'hF0000` (DF) with `SRCRDY` delayed 3 cycles and `MDR_RAM=16'hA5A5` → `SELDF=1`, `SLDFLASH=1`, `SELMEM=0` for 4 cycles; `HSTACK` in cycle 5; `HSTRDATA=16'hA5A5`; `CPURDATA` unchanged.
- Both requesters assert in the same cycle, repeatedly → grants alternate CPU, host, CPU, host; each ACK goes only to its owner.
- Walk the decode: CPU addresses 20'h80000, 20'hA0000, 20'hC0000, 20'hE0000 → exactly `SELTRACE`, `SELSTATE`, `SELBRK`, `SELHOSTIF` respectively; all selects low in IDLE/DONE.
- `RESB` pulsed low during SEL → outputs 0 at once, no ACK afterwards; the pending `CPUREQ` is re-served from IDLE after release.
- With `ORBUS_TMO_EN` and `TMO_W=4`, `SRCRDY` held 0 → ACK after 15 SEL cycles, `RDERR=1`, RDATA=16'hFFFF. Without the macro, `BUSY` stays 1 and there is no ACK.

Source files
------------

// File: rtl/orbus_read_ctl_if.sv
// Bundle of the OR-bus read controller signals: requester handshakes, source selects and OR-bus data.
// The controller binds the slave modport; requesters/sources (or a bench) bind master.
interface orbus_read_ctl_if #(
  parameter int ADR_W = 20
);
  logic             CPUREQ;
  logic [ADR_W-1:0] CPUADR;
  logic             CPUACK;
  logic [15:0]      CPURDATA;
  logic             HSTREQ;
  logic [ADR_W-1:0] HSTADR;
  logic             HSTACK;
  logic [15:0]      HSTRDATA;
  logic             RDERR;
  logic             SELMEM;
  logic             SELTRACE;
  logic             SELSTATE;
  logic             SELBRK;
  logic             SELHOSTIF;
  logic             SELDF;
  logic             SLDFLASH;
  logic             SRCRDY;
  logic [15:0]      MDR_RAM;
  logic             BUSY;

  modport slave (
    input  CPUREQ, CPUADR, HSTREQ, HSTADR, SRCRDY, MDR_RAM,
    output CPUACK, CPURDATA, HSTACK, HSTRDATA, RDERR,
           SELMEM, SELTRACE, SELSTATE, SELBRK, SELHOSTIF, SELDF, SLDFLASH, BUSY
  );

  modport master (
    output CPUREQ, CPUADR, HSTREQ, HSTADR, SRCRDY, MDR_RAM,
    input  CPUACK, CPURDATA, HSTACK, HSTRDATA, RDERR,
           SELMEM, SELTRACE, SELSTATE, SELBRK, SELHOSTIF, SELDF, SLDFLASH, BUSY
  );
endinterface

// File: rtl/orbus_read_ctl.sv
// OR-bus read-cycle controller: round-robin CPU/host arbitration, source decode, capture of MDR_RAM.
// Optional read timeout is built only when ORBUS_TMO_EN is defined.
module orbus_read_ctl #(
  parameter int ADR_W = 20,
  parameter int TMO_W = 8
) (
  input logic            CLK,
  input logic            RESB,
  orbus_read_ctl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_HST = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  // Only the top four address bits take part in the decode, so only they are latched.
  logic [3:0]  tag_q, tag_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic [15:0] hst_rdata_q, hst_rdata_d;
  logic        err_q, err_d;

  logic        cpu_wins;
  logic        tmo_hit;
  logic        sel_mem, sel_trace, sel_state, sel_brk, sel_hostif, sel_df, sl_dflash;
  logic        unused_adr;

  assign unused_adr = ^{bus.CPUADR[ADR_W-5:0], bus.HSTADR[ADR_W-5:0]};

  // On a tie the requester that was not served last wins; a lone request always wins.
  assign cpu_wins = bus.CPUREQ && (!bus.HSTREQ || (last_q == OWN_HST));

`ifdef ORBUS_TMO_EN
  // The SEL cycle being evaluated is itself counted, so the timeout lands on SEL cycle 2^TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_SEL) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == ST_SEL) && (tmo_cnt_q == TMO_LAST);
`else
  logic [TMO_W-1:0] unused_tmo;

  assign unused_tmo = '0;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_HST;
      tag_q       <= '0;
      cpu_rdata_q <= '0;
      hst_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      tag_q       <= tag_d;
      cpu_rdata_q <= cpu_rdata_d;
      hst_rdata_q <= hst_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    tag_d       = tag_q;
    cpu_rdata_d = cpu_rdata_q;
    hst_rdata_d = hst_rdata_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.CPUREQ || bus.HSTREQ) begin
          owner_d = cpu_wins ? OWN_CPU : OWN_HST;
          last_d  = cpu_wins ? OWN_CPU : OWN_HST;
          tag_d   = cpu_wins ? bus.CPUADR[ADR_W-1 -: 4] : bus.HSTADR[ADR_W-1 -: 4];
          err_d   = 1'b0;
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        // A late ready still wins over a timeout in the same cycle.
        if (bus.SRCRDY) begin
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = bus.MDR_RAM;
          end else begin
            hst_rdata_d = bus.MDR_RAM;
          end
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = 16'hFFFF;
          end else begin
            hst_rdata_d = 16'hFFFF;
          end
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Selects are driven only while in SEL; SLDFLASH rides with the DataFlash select alone.
  always_comb begin
    sel_mem    = 1'b0;
    sel_trace  = 1'b0;
    sel_state  = 1'b0;
    sel_brk    = 1'b0;
    sel_hostif = 1'b0;
    sel_df     = 1'b0;
    sl_dflash  = 1'b0;
    if (state_q == ST_SEL) begin
      if (!tag_q[3]) begin
        sel_mem = 1'b1;
      end else begin
        unique case (tag_q[2:1])
          2'b00:   sel_trace = 1'b1;
          2'b01:   sel_state = 1'b1;
          2'b10:   sel_brk   = 1'b1;
          default: begin
            if (tag_q[0]) begin
              sel_df    = 1'b1;
              sl_dflash = 1'b1;
            end else begin
              sel_hostif = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.SELMEM    = sel_mem;
  assign bus.SELTRACE  = sel_trace;
  assign bus.SELSTATE  = sel_state;
  assign bus.SELBRK    = sel_brk;
  assign bus.SELHOSTIF = sel_hostif;
  assign bus.SELDF     = sel_df;
  assign bus.SLDFLASH  = sl_dflash;

  assign bus.CPUACK   = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign bus.HSTACK   = (state_q == ST_DONE) && (owner_q == OWN_HST);
  assign bus.RDERR    = (state_q == ST_DONE) && err_q;
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.CPURDATA = cpu_rdata_q;
  assign bus.HSTRDATA = hst_rdata_q;

endmodule

// File: tb/tb_orbus_read_ctl.sv
// Self-checking bench for orbus_read_ctl: directed reads, arbitration ties, decode walk, random traffic, reset abort.
// Expected selects, winners and read data come from a small address-region / round-robin model.
module tb_orbus_read_ctl;

  localparam int ADR_W = 20;
  localparam int TMO_W = 4;

  logic clk  = 1'b0;
  logic resb = 1'b0;

  always #5 clk = ~clk;

  orbus_read_ctl_if #(.ADR_W(ADR_W)) bus ();

  orbus_read_ctl #(.ADR_W(ADR_W), .TMO_W(TMO_W)) dut (
    .CLK  (clk),
    .RESB (resb),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] cpu_exp;
  logic [15:0] hst_exp;
  bit          last_hst;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {MEM, TRACE, STATE, BRK, HOSTIF, DF, SLDFLASH} from the address region (top nibble)
  function automatic logic [6:0] exp_sel(input logic [19:0] adr);
    int region;
    region = int'(adr / 20'h10000);
    if (region < 8)       return 7'b1000000;
    else if (region < 10) return 7'b0100000;
    else if (region < 12) return 7'b0010000;
    else if (region < 14) return 7'b0001000;
    else if (region == 14) return 7'b0000100;
    else                  return 7'b0000011;
  endfunction

  function automatic logic [6:0] dut_sel();
    return {bus.SELMEM, bus.SELTRACE, bus.SELSTATE, bus.SELBRK, bus.SELHOSTIF, bus.SELDF, bus.SLDFLASH};
  endfunction

  function automatic logic [3:0] dut_ctl();
    return {bus.CPUACK, bus.HSTACK, bus.RDERR, bus.BUSY};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    cpu_exp  = 16'h0000;
    hst_exp  = 16'h0000;
    last_hst = 1'b1;
  endtask

  // Called in an IDLE cycle; runs one full read and returns in the following IDLE cycle.
  task automatic serve(input bit cr, input bit hr, input logic [19:0] ca, input logic [19:0] ha,
                       input int delay, input logic [15:0] data, input bit scramble, input bit late);
    bit          cpu_win;
    logic [6:0]  es;
    bus.CPUREQ  = cr;
    bus.HSTREQ  = hr;
    bus.CPUADR  = ca;
    bus.HSTADR  = ha;
    bus.SRCRDY  = 1'($urandom);
    bus.MDR_RAM = 16'($urandom);
    check("idle_ctl", {28'd0, dut_ctl()}, 32'h0);
    check("idle_sel", {25'd0, dut_sel()}, 32'h0);
    if (cr && hr) cpu_win = last_hst;
    else          cpu_win = cr;
    last_hst = !cpu_win;
    es = exp_sel(cpu_win ? ca : ha);
    tick();
    for (int k = 0; k <= delay; k++) begin
      check("sel_decode", {25'd0, dut_sel()}, {25'd0, es});
      check("sel_ctl", {28'd0, dut_ctl()}, 32'h1);
      bus.SRCRDY  = (k == delay);
      bus.MDR_RAM = (k == delay) ? data : 16'($urandom);
      if (scramble) begin
        if (cpu_win) bus.CPUADR = 20'($urandom);
        else         bus.HSTADR = 20'($urandom);
      end
      if (late && k == 0) begin
        if (cpu_win && !bus.HSTREQ) begin
          bus.HSTREQ = 1'b1;
          bus.HSTADR = 20'($urandom);
        end else if (!cpu_win && !bus.CPUREQ) begin
          bus.CPUREQ = 1'b1;
          bus.CPUADR = 20'($urandom);
        end
      end
      tick();
    end
    bus.SRCRDY  = 1'($urandom);
    bus.MDR_RAM = 16'($urandom);
    if (cpu_win) cpu_exp = data;
    else         hst_exp = data;
    check("done_ctl", {28'd0, dut_ctl()}, {28'd0, cpu_win, !cpu_win, 1'b0, 1'b1});
    check("done_sel", {25'd0, dut_sel()}, 32'h0);
    check("cpu_rdata", {16'd0, bus.CPURDATA}, {16'd0, cpu_exp});
    check("hst_rdata", {16'd0, bus.HSTRDATA}, {16'd0, hst_exp});
    if (cpu_win) bus.CPUREQ = 1'b0;
    else         bus.HSTREQ = 1'b0;
    tick();
    check("post_ctl", {28'd0, dut_ctl()}, 32'h0);
  endtask

  initial begin
    logic [19:0] walk [4];
    bit          cr, hr;
    logic [19:0] ca, ha;

    bus.CPUREQ  = 1'b0;
    bus.HSTREQ  = 1'b0;
    bus.CPUADR  = '0;
    bus.HSTADR  = '0;
    bus.SRCRDY  = 1'b0;
    bus.MDR_RAM = '0;
    model_reset();

    // Reset state
    tick();
    tick();
    check("rst_ctl", {28'd0, dut_ctl()}, 32'h0);
    check("rst_sel", {25'd0, dut_sel()}, 32'h0);
    check("rst_rdata", {bus.CPURDATA, bus.HSTRDATA}, 32'h0);
    resb = 1'b1;

    // Single CPU read, immediate ready
    serve(1'b1, 1'b0, 20'h00100, 20'h0, 0, 16'h1234, 1'b0, 1'b0);
    // Host DataFlash read with 3 wait cycles
    serve(1'b0, 1'b1, 20'h0, 20'hF0000, 3, 16'hA5A5, 1'b0, 1'b0);

    // Simultaneous requests: grants alternate
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 1'b1, 20'h12345, 20'h9ABCD, int'($urandom_range(0, 2)), 16'($urandom), 1'b0, 1'b0);
    end
    serve(bus.CPUREQ, bus.HSTREQ, bus.CPUADR, bus.HSTADR, 0, 16'($urandom), 1'b0, 1'b0);

    // Decode walk, with address changes after grant
    walk[0] = 20'h80000;
    walk[1] = 20'hA0000;
    walk[2] = 20'hC0000;
    walk[3] = 20'hE0000;
    for (int i = 0; i < 4; i++) begin
      serve(1'b1, 1'b0, walk[i], 20'h0, int'($urandom_range(0, 2)), 16'($urandom), 1'b1, 1'b0);
    end

    // Random traffic; pending requesters keep their request and address
    for (int i = 0; i < 40; i++) begin
      cr = bus.CPUREQ || 1'($urandom);
      hr = bus.HSTREQ || 1'($urandom);
      if (!cr && !hr) cr = 1'b1;
      ca = bus.CPUREQ ? bus.CPUADR : 20'($urandom);
      ha = bus.HSTREQ ? bus.HSTADR : 20'($urandom);
      serve(cr, hr, ca, ha, int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int n = 0; n < 4 && (bus.CPUREQ || bus.HSTREQ); n++) begin
      serve(bus.CPUREQ, bus.HSTREQ, bus.CPUADR, bus.HSTADR, 0, 16'($urandom), 1'b0, 1'b0);
    end
    check("drained", {30'd0, bus.CPUREQ, bus.HSTREQ}, 32'h0);

    // Reset pulsed during SEL aborts the read; the CPU request is re-served afterwards
    bus.CPUREQ = 1'b1;
    bus.CPUADR = 20'h00100;
    bus.SRCRDY = 1'b0;
    tick();
    check("abort_sel", {25'd0, dut_sel()}, 32'h40);
    resb = 1'b0;
    model_reset();
    #1;
    check("abort_ctl", {28'd0, dut_ctl()}, 32'h0);
    check("abort_selz", {25'd0, dut_sel()}, 32'h0);
    check("abort_rdata", {bus.CPURDATA, bus.HSTRDATA}, 32'h0);
    tick();
    tick();
    check("abort_noack", {28'd0, dut_ctl()}, 32'h0);
    resb = 1'b1;
    serve(1'b1, 1'b0, 20'h00100, 20'h0, 1, 16'h5A5A, 1'b0, 1'b0);

    // Source never ready
    bus.CPUREQ = 1'b1;
    bus.CPUADR = 20'h00100;
    bus.SRCRDY = 1'b0;
    tick();
`ifdef ORBUS_TMO_EN
    for (int k = 0; k < 15; k++) begin
      check("tmo_wait", {28'd0, dut_ctl()}, 32'h1);
      bus.SRCRDY = 1'b0;
      tick();
    end
    check("tmo_ack", {28'd0, dut_ctl()}, 32'hB);
    check("tmo_rdata", {16'd0, bus.CPURDATA}, 32'hFFFF);
    bus.CPUREQ = 1'b0;
    tick();
`else
    for (int k = 0; k < 40; k++) begin
      check("hang_busy", {28'd0, dut_ctl()}, 32'h1);
      tick();
    end
    check("hang_rdata", {16'd0, bus.CPURDATA}, 32'h5A5A);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
